// File: rtl/nanci_pkg.sv
// Shared types, default widths and request packing for the node sequencer.
package nanci_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 10;
  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned CNT_W          = 14;

  // Widest field the pack helper accepts; callers zero-extend into it.
  localparam int unsigned MAX_FIELD_W = 32;
  localparam int unsigned PACK_W      = 2 * MAX_FIELD_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    COMPUTE,
    ISSUE,
    WAIT_RESP
  } state_t;

  // Build {flag, addr, data} for arbitrary field widths aw/dw.
  function automatic logic [PACK_W-1:0] pack_req(
    input logic                   flag,
    input logic [MAX_FIELD_W-1:0] addr,
    input logic [MAX_FIELD_W-1:0] data,
    input int unsigned            aw,
    input int unsigned            dw
  );
    pack_req = (PACK_W'(flag) << (aw + dw)) | (PACK_W'(addr) << dw) | PACK_W'(data);
  endfunction

endpackage

// File: rtl/app_node_sequencer_if.sv
// Network-side request/response bundle of one node sequencer.
interface app_node_sequencer_if
  import nanci_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  localparam int unsigned RW = ADDR_WIDTH + DATA_WIDTH + 1;

  logic                  net_req_valid;
  logic [RW-1:0]         net_req;
  logic                  net_req_ready;
  logic                  net_resp_valid;
  logic [DATA_WIDTH-1:0] net_resp_data;

  modport master (
    output net_req_valid,
    output net_req,
    input  net_req_ready,
    input  net_resp_valid,
    input  net_resp_data
  );

  modport slave (
    input  net_req_valid,
    input  net_req,
    output net_req_ready,
    output net_resp_valid,
    output net_resp_data
  );

endinterface

// File: rtl/cycle_down_counter.sv
// Loadable down counter; a load of 0 is treated as 1 so the delay is never empty.
module cycle_down_counter
  import nanci_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             expire_c
);

  logic [CNT_W-1:0] count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= (load_value == '0) ? CNT_W'(1) : load_value;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expire_c = (count == CNT_W'(1));

endmodule

// File: rtl/app_node_sequencer.sv
// Per-node driver: triggers the application, models its compute time,
// issues its request to the network and returns read data.
module app_node_sequencer
  import nanci_pkg::*;
#(
  parameter int unsigned N          = 1024,
  parameter int unsigned I          = 0,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_ITERS  = 1,
  parameter int unsigned ITER_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           runnable,
  input  logic [ADDR_WIDTH+DATA_WIDTH:0] app_request,
  input  logic [CNT_W-1:0]               compute_cycles,
  output logic [ADDR_WIDTH+DATA_WIDTH:0] nanci_result,
  output logic                           busy,
  output logic                           done,
  output logic [ITER_WIDTH-1:0]          iter_count,
  app_node_sequencer_if.master           net
);

  localparam int unsigned W         = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned RW        = W + 1;
  localparam int unsigned WRITE_BIT = W;
  localparam int unsigned ADDR_MSB  = W - 1;
  localparam int unsigned ADDR_LSB  = DATA_WIDTH;

  state_t                state_q, state_d;
  logic                  runnable_d, busy_d, done_d, net_req_valid_d;
  logic [RW-1:0]         net_req_d, nanci_result_d;
  logic [ITER_WIDTH-1:0] iter_count_d;
  logic                  cnt_load_c, cnt_dec_c, cnt_expire_c;
  logic                  handshake_c, iter_done_c, last_iter_c;

  // Node identity is carried for debug visibility only.
  logic [63:0] unused_node_cfg_c;
  assign unused_node_cfg_c = {32'(N), 32'(I)};

  // Compute-latency timer.
  cycle_down_counter u_compute_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load_c),
    .load_value (compute_cycles),
    .dec        (cnt_dec_c),
    .expire_c   (cnt_expire_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and next values of all registered outputs.
  always_comb begin
    state_d        = state_q;
    done_d         = done;
    iter_count_d   = iter_count;
    net_req_d      = net.net_req;
    nanci_result_d = nanci_result;
    cnt_load_c     = 1'b0;
    cnt_dec_c      = 1'b0;
    iter_done_c    = 1'b0;
    handshake_c    = net.net_req_valid && net.net_req_ready;
    last_iter_c    = ((iter_count + ITER_WIDTH'(1)) == ITER_WIDTH'(NUM_ITERS));

    case (state_q)
      IDLE: begin
        if (start) begin
          if (NUM_ITERS != 0) begin
            state_d      = RUN;
            done_d       = 1'b0;
            iter_count_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        cnt_load_c = 1'b1;
        state_d    = COMPUTE;
      end
      COMPUTE: begin
        cnt_dec_c = 1'b1;
        if (cnt_expire_c) begin
          net_req_d = app_request;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (handshake_c) begin
          if (net.net_req[WRITE_BIT]) iter_done_c = 1'b1;
          else                        state_d     = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (net.net_resp_valid) begin
          nanci_result_d = RW'(pack_req(1'b1,
                                        MAX_FIELD_W'(net.net_req[ADDR_MSB:ADDR_LSB]),
                                        MAX_FIELD_W'(net.net_resp_data),
                                        ADDR_WIDTH, DATA_WIDTH));
          iter_done_c    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (iter_done_c) begin
      iter_count_d = iter_count + ITER_WIDTH'(1);
      if (last_iter_c) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        state_d = RUN;
      end
    end

    runnable_d      = (state_d == RUN);
    busy_d          = (state_d != IDLE);
    net_req_valid_d = (state_d == ISSUE);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      runnable          <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      iter_count        <= '0;
      nanci_result      <= '0;
      net.net_req_valid <= 1'b0;
      net.net_req       <= '0;
    end else begin
      runnable          <= runnable_d;
      busy              <= busy_d;
      done              <= done_d;
      iter_count        <= iter_count_d;
      nanci_result      <= nanci_result_d;
      net.net_req_valid <= net_req_valid_d;
      net.net_req       <= net_req_d;
    end
  end

endmodule

// File: tb/tb_app_node_sequencer.sv
// Directed bench: one single-iteration node and one three-iteration node.
module tb_app_node_sequencer;

  localparam int unsigned DW = 10;
  localparam int unsigned AW = 10;
  localparam int unsigned RW = AW + DW + 1;
  localparam int unsigned IW = 16;

  logic          clk = 1'b0;
  logic          rst, start_a, start_b, ready, resp_valid;
  logic [RW-1:0] app_req;
  logic [13:0]   ccycles;
  logic [DW-1:0] resp_data;

  logic          run_a, busy_a, done_a, run_b, busy_b, done_b;
  logic [RW-1:0] nres_a, nres_b;
  logic [IW-1:0] iter_a, iter_b;

  int checks = 0;
  int fails  = 0;

  app_node_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) net_a ();
  app_node_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) net_b ();

  assign net_a.net_req_ready  = ready;
  assign net_a.net_resp_valid = resp_valid;
  assign net_a.net_resp_data  = resp_data;
  assign net_b.net_req_ready  = ready;
  assign net_b.net_resp_valid = resp_valid;
  assign net_b.net_resp_data  = resp_data;

  app_node_sequencer #(.N(1024), .I(0), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                       .NUM_ITERS(1), .ITER_WIDTH(IW)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .runnable(run_a),
    .app_request(app_req), .compute_cycles(ccycles), .nanci_result(nres_a),
    .busy(busy_a), .done(done_a), .iter_count(iter_a), .net(net_a)
  );

  app_node_sequencer #(.N(1024), .I(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                       .NUM_ITERS(3), .ITER_WIDTH(IW)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .runnable(run_b),
    .app_request(app_req), .compute_cycles(ccycles), .nanci_result(nres_b),
    .busy(busy_b), .done(done_b), .iter_count(iter_b), .net(net_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and land 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready = 1'b1;
    resp_valid = 1'b0; resp_data = '0; app_req = '0; ccycles = '0;
    step(); step();

    // Reset state
    check("rst_runnable", 32'(run_a), 'h0);
    check("rst_valid",    32'(net_a.net_req_valid), 'h0);
    check("rst_net_req",  32'(net_a.net_req), 'h0);
    check("rst_nres",     32'(nres_a), 'h0);
    check("rst_busy",     32'(busy_a), 'h0);
    check("rst_done",     32'(done_a), 'h0);
    check("rst_iter",     32'(iter_a), 'h0);
    check("rst_b_busy",   32'(busy_b), 'h0);
    rst = 1'b0;

    // Write path: addr 1023, data 0x3FF, C=5, ready high
    app_req = 21'h1FFFFF; ccycles = 14'd5; ready = 1'b1;
    start_a = 1'b1; step(); start_a = 1'b0;               // cycle 1
    check("wr_c1_runnable", 32'(run_a), 'h1);
    check("wr_c1_busy",     32'(busy_a), 'h1);
    check("wr_c1_valid",    32'(net_a.net_req_valid), 'h0);
    for (int c = 2; c <= 6; c++) begin
      step();
      check($sformatf("wr_c%0d_runnable", c), 32'(run_a), 'h0);
      check($sformatf("wr_c%0d_valid", c), 32'(net_a.net_req_valid), 'h0);
    end
    step();                                                // cycle 7
    check("wr_c7_valid",   32'(net_a.net_req_valid), 'h1);
    check("wr_c7_net_req", 32'(net_a.net_req), 'h1FFFFF);
    check("wr_c7_done",    32'(done_a), 'h0);
    step();                                                // cycle 8
    check("wr_c8_done",  32'(done_a), 'h1);
    check("wr_c8_valid", 32'(net_a.net_req_valid), 'h0);
    check("wr_c8_busy",  32'(busy_a), 'h0);
    check("wr_c8_iter",  32'(iter_a), 'h1);
    check("wr_c8_nres",  32'(nres_a), 'h0);

    // Backpressure: ready low for cycles 7-10
    ready = 1'b0;
    start_a = 1'b1; step(); start_a = 1'b0;               // cycle 1
    check("bp_c1_done", 32'(done_a), 'h0);
    check("bp_c1_iter", 32'(iter_a), 'h0);
    for (int c = 2; c <= 6; c++) step();
    for (int c = 7; c <= 10; c++) begin
      step();
      check($sformatf("bp_c%0d_valid", c), 32'(net_a.net_req_valid), 'h1);
      check($sformatf("bp_c%0d_net_req", c), 32'(net_a.net_req), 'h1FFFFF);
    end
    step();                                                // cycle 11
    ready = 1'b1;
    check("bp_c11_valid",   32'(net_a.net_req_valid), 'h1);
    check("bp_c11_net_req", 32'(net_a.net_req), 'h1FFFFF);
    check("bp_c11_done",    32'(done_a), 'h0);
    step();                                                // cycle 12
    check("bp_c12_done",  32'(done_a), 'h1);
    check("bp_c12_valid", 32'(net_a.net_req_valid), 'h0);

    // Read path: addr 5, response 0x2A three cycles after handshake
    app_req = 21'h001400; ccycles = 14'd5;
    start_a = 1'b1; step(); start_a = 1'b0;               // cycle 1
    step();                                                // cycle 2
    step();                                                // cycle 3
    resp_valid = 1'b1; resp_data = 10'h03C;
    step();                                                // cycle 4
    resp_valid = 1'b0;
    check("rd_stray_nres", 32'(nres_a), 'h0);
    check("rd_c4_busy",    32'(busy_a), 'h1);
    step(); step(); step();                                // cycle 7
    check("rd_c7_valid",   32'(net_a.net_req_valid), 'h1);
    check("rd_c7_net_req", 32'(net_a.net_req), 'h001400);
    step();                                                // cycle 8
    check("rd_c8_valid", 32'(net_a.net_req_valid), 'h0);
    check("rd_c8_busy",  32'(busy_a), 'h1);
    check("rd_c8_done",  32'(done_a), 'h0);
    step();                                                // cycle 9
    step();                                                // cycle 10
    resp_valid = 1'b1; resp_data = 10'h02A;
    step();                                                // cycle 11
    resp_valid = 1'b0;
    check("rd_c11_nres", 32'(nres_a), 'h10142A);
    check("rd_c11_done", 32'(done_a), 'h1);
    check("rd_c11_busy", 32'(busy_a), 'h0);
    check("rd_c11_iter", 32'(iter_a), 'h1);

    // compute_cycles = 0: one COMPUTE cycle, write leaves nanci_result alone
    app_req = 21'h100C07; ccycles = 14'd0;
    start_a = 1'b1; step(); start_a = 1'b0;               // cycle 1
    check("c0_c1_runnable", 32'(run_a), 'h1);
    step();                                                // cycle 2
    check("c0_c2_valid", 32'(net_a.net_req_valid), 'h0);
    check("c0_c2_busy",  32'(busy_a), 'h1);
    step();                                                // cycle 3
    check("c0_c3_valid",   32'(net_a.net_req_valid), 'h1);
    check("c0_c3_net_req", 32'(net_a.net_req), 'h100C07);
    step();                                                // cycle 4
    check("c0_c4_done", 32'(done_a), 'h1);
    check("c0_c4_nres", 32'(nres_a), 'h10142A);

    // Three iterations on node b; start while busy is ignored
    app_req = 21'h1FFFFF; ccycles = 14'd5; ready = 1'b1;
    start_b = 1'b1; step(); start_b = 1'b0;               // cycle 1
    for (int c = 1; c <= 21; c++) begin
      check($sformatf("it_c%0d_runnable", c), 32'(run_b),
            (c == 1 || c == 8 || c == 15) ? 'h1 : 'h0);
      check($sformatf("it_c%0d_busy", c), 32'(busy_b), 'h1);
      if (c == 9)  check("it_c9_iter", 32'(iter_b), 'h1);
      if (c == 16) check("it_c16_iter", 32'(iter_b), 'h2);
      if (c == 10) check("it_c10_done", 32'(done_b), 'h0);
      if (c == 4) start_b = 1'b1;
      if (c == 5) start_b = 1'b0;
      step();
    end                                                    // cycle 22
    check("it_c22_done",     32'(done_b), 'h1);
    check("it_c22_iter",     32'(iter_b), 'h3);
    check("it_c22_busy",     32'(busy_b), 'h0);
    check("it_c22_runnable", 32'(run_b), 'h0);

    // Reset in ISSUE with ready low, then a fresh run
    app_req = 21'h1FFFFF; ccycles = 14'd5; ready = 1'b0;
    start_a = 1'b1; step(); start_a = 1'b0;               // cycle 1
    for (int c = 2; c <= 7; c++) step();                   // cycle 7
    check("rs_c7_valid", 32'(net_a.net_req_valid), 'h1);
    rst = 1'b1;
    step();                                                // cycle 8
    check("rs_valid", 32'(net_a.net_req_valid), 'h0);
    check("rs_busy",  32'(busy_a), 'h0);
    check("rs_done",  32'(done_a), 'h0);
    check("rs_nres",  32'(nres_a), 'h0);
    check("rs_iter",  32'(iter_a), 'h0);
    check("rs_req",   32'(net_a.net_req), 'h0);
    rst = 1'b0; ready = 1'b1; ccycles = 14'd0; app_req = 21'h100C07;
    start_a = 1'b1; step(); start_a = 1'b0;               // cycle 1
    check("rs2_c1_runnable", 32'(run_a), 'h1);
    step();                                                // cycle 2
    step();                                                // cycle 3
    check("rs2_c3_valid",   32'(net_a.net_req_valid), 'h1);
    check("rs2_c3_net_req", 32'(net_a.net_req), 'h100C07);
    step();                                                // cycle 4
    check("rs2_c4_done", 32'(done_a), 'h1);
    check("rs2_c4_iter", 32'(iter_a), 'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
